seg7_ctrl: RTL and testbench

Bus-slave controller for the six DE10-Lite seven-segment displays. It sits downstream of the system data bus (DATABUS_/ADDRBUS_ widths), holds the display value, decimal-point, blank and blink registers, and drives `seg7p_t` outputs. All outputs are registered, and a free-running prescaler supplies the blink phase.

---
 rtl/seg7_ctrl_pkg.sv | 51 +++++
 rtl/seg7_ctrl_if.sv | 28 ++
 rtl/seg7_ctrl_hexfont.sv | 46 ++++
 rtl/seg7_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_seg7_ctrl.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/seg7_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : seg7_ctrl_pkg
// Brief   : Shared types and constants for the seven-segment bus controller.
// Rev     : 1.0 - initial release
// ============================================================================
package seg7_ctrl_pkg;

  // System bus widths
  localparam int DATABUS_ = 16;
  localparam int ADDRBUS_ = 32;

  // Number of seven-segment digits driven by the controller
  localparam int NUM_DIGITS = 6;

  // One display digit, active-low; segment a is the MSB, decimal point last
  typedef struct packed {
    logic a;
    logic b;
    logic c;
    logic d;
    logic e;
    logic f;
    logic g;
    logic p;
  } seg7p_t;

  // All segments dark
  localparam seg7p_t SEG7P_OFF = 8'hFF;

  // Register offsets in 16-bit words within the window
  localparam logic [2:0] SEG_VAL_LO = 3'd0;
  localparam logic [2:0] SEG_VAL_HI = 3'd1;
  localparam logic [2:0] SEG_DP     = 3'd2;
  localparam logic [2:0] SEG_BLANK  = 3'd3;
  localparam logic [2:0] SEG_CTRL   = 3'd4;

  // Bus handshake states
  typedef enum logic [0:0] {
    BUS_IDLE = 1'b0,
    BUS_ACK  = 1'b1
  } bus_state_e;

  // Window match on the 16-byte aligned block address
  function automatic logic win_hit(input logic [ADDRBUS_-1:0] addr,
                                   input logic [ADDRBUS_-1:0] base);
    return addr[ADDRBUS_-1:4] == base[ADDRBUS_-1:4];
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : seg7_ctrl_if
// Brief   : Request/acknowledge register bus between master and controller.
// Rev     : 1.0 - initial release
// ============================================================================
interface seg7_ctrl_if;
  import seg7_ctrl_pkg::*;

  logic                req;
  logic                we;
  logic [ADDRBUS_-1:0] addr;
  logic [DATABUS_-1:0] wdata;
  logic [DATABUS_-1:0] rdata;
  logic                ack;

  modport master (
    output req, we, addr, wdata,
    input  rdata, ack
  );

  modport slave (
    input  req, we, addr, wdata,
    output rdata, ack
  );

endinterface
`default_nettype wire

// File: rtl/seg7_ctrl_hexfont.sv
`default_nettype none
// ============================================================================
// Module  : seg7_hexfont
// Brief   : Combinational hex font, nibble plus decimal point to active-low
//           segment pattern.
// Rev     : 1.0 - initial release
// ============================================================================
module seg7_hexfont
  import seg7_ctrl_pkg::*;
(
  input  logic [3:0] nib_i,
  input  logic       dp_i,
  output seg7p_t     seg_o
);

  logic [6:0] abcdefg;

  // Nibble to a..g pattern, 0 = segment lit
  always_comb begin
    abcdefg = 7'h7F;
    case (nib_i)
      4'h0:    abcdefg = 7'b000_0001;
      4'h1:    abcdefg = 7'b100_1111;
      4'h2:    abcdefg = 7'b001_0010;
      4'h3:    abcdefg = 7'b000_0110;
      4'h4:    abcdefg = 7'b100_1100;
      4'h5:    abcdefg = 7'b010_0100;
      4'h6:    abcdefg = 7'b010_0000;
      4'h7:    abcdefg = 7'b000_1111;
      4'h8:    abcdefg = 7'b000_0000;
      4'h9:    abcdefg = 7'b000_0100;
      4'hA:    abcdefg = 7'b000_1000;
      4'hB:    abcdefg = 7'b110_0000;
      4'hC:    abcdefg = 7'b011_0001;
      4'hD:    abcdefg = 7'b100_0010;
      4'hE:    abcdefg = 7'b011_0000;
      4'hF:    abcdefg = 7'b011_1000;
      default: abcdefg = 7'h7F;
    endcase
  end

  // Decimal point is active-low like the other segments
  assign seg_o = {abcdefg, ~dp_i};

endmodule
`default_nettype wire

// File: rtl/seg7_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : seg7_ctrl
// Brief   : Bus-slave controller for six seven-segment displays: value, DP,
//           blank and blink registers, blink prescaler, registered outputs.
// Rev     : 1.0 - initial release
// ============================================================================
module seg7_ctrl
  import seg7_ctrl_pkg::*;
#(
  parameter logic [ADDRBUS_-1:0] BASE_ADDR = 32'h0000_1000,
  parameter int                  BLINK_DIV = 25_000_000
)(
  input  logic                       clk,
  input  logic                       rst_n,
  seg7_ctrl_if.slave                 bus,
  output seg7p_t [NUM_DIGITS-1:0]    hex
);

  localparam int             CNT_W    = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);

  // Bus FSM and response registers
  bus_state_e          state_q, state_d;
  logic [DATABUS_-1:0] rdata_q, rdata_d;

  // Register file
  logic [15:0] val_lo_q, val_lo_d;
  logic [7:0]  val_hi_q, val_hi_d;
  logic [5:0]  dp_q,     dp_d;
  logic [5:0]  blank_q,  blank_d;
  logic        ctrl_q,   ctrl_d;

  // Blink prescaler; phase 1 = digits shown
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             phase_q, phase_d;

  // Output stage
  seg7p_t [NUM_DIGITS-1:0] hex_q, hex_d;
  seg7p_t                  font [NUM_DIGITS];
  logic [23:0]             digits;

  // Decode
  logic                hit;
  logic                accept;
  logic                wr;
  logic [2:0]          offset;
  logic [DATABUS_-1:0] rd_mux;
  logic                unused_addr_lsb;

  assign hit             = win_hit(bus.addr, BASE_ADDR);
  assign offset          = bus.addr[3:1];
  assign wr              = accept && bus.we;
  assign unused_addr_lsb = bus.addr[0];

  // Accept a hit only from IDLE so ack can never fire on back-to-back cycles
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      BUS_IDLE: begin
        if (bus.req && hit) begin
          accept  = 1'b1;
          state_d = BUS_ACK;
        end
      end
      BUS_ACK:  state_d = BUS_IDLE;
      default:  state_d = BUS_IDLE;
    endcase
  end

  // Read mux over pre-edge register contents; unused bits and reserved read 0
  always_comb begin
    rd_mux = '0;
    case (offset)
      SEG_VAL_LO: rd_mux = val_lo_q;
      SEG_VAL_HI: rd_mux = {8'h00, val_hi_q};
      SEG_DP:     rd_mux = {10'h000, dp_q};
      SEG_BLANK:  rd_mux = {10'h000, blank_q};
      SEG_CTRL:   rd_mux = {15'h0000, ctrl_q};
      default:    rd_mux = '0;
    endcase
  end

  // Register writes and read-data capture for the accepted request
  always_comb begin
    val_lo_d = val_lo_q;
    val_hi_d = val_hi_q;
    dp_d     = dp_q;
    blank_d  = blank_q;
    ctrl_d   = ctrl_q;
    rdata_d  = accept ? rd_mux : '0;
    if (wr) begin
      case (offset)
        SEG_VAL_LO: val_lo_d = bus.wdata;
        SEG_VAL_HI: val_hi_d = bus.wdata[7:0];
        SEG_DP:     dp_d     = bus.wdata[5:0];
        SEG_BLANK:  blank_d  = bus.wdata[5:0];
        SEG_CTRL:   ctrl_d   = bus.wdata[0];
        default:    ;
      endcase
    end
  end

  // Bus state, response and register file flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= BUS_IDLE;
      rdata_q  <= '0;
      val_lo_q <= '0;
      val_hi_q <= '0;
      dp_q     <= '0;
      blank_q  <= 6'h3F;
      ctrl_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rdata_q  <= rdata_d;
      val_lo_q <= val_lo_d;
      val_hi_q <= val_hi_d;
      dp_q     <= dp_d;
      blank_q  <= blank_d;
      ctrl_q   <= ctrl_d;
    end
  end

  // Prescaler next state; a CTRL write restarts the blink cycle in phase on
  always_comb begin
    cnt_d   = cnt_q + CNT_W'(1);
    phase_d = phase_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end
    if (wr && (offset == SEG_CTRL)) begin
      cnt_d   = '0;
      phase_d = 1'b1;
    end
  end

  // Prescaler flops, free running regardless of blink enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      phase_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign digits = {val_hi_q, val_lo_q};

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      seg7_hexfont u_font (
        .nib_i (digits[4*gi +: 4]),
        .dp_i  (dp_q[gi]),
        .seg_o (font[gi])
      );
    end
  endgenerate

  // Per-digit blanking, either explicit or during the blink off phase
  always_comb begin
    hex_d = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      hex_d[i] = (blank_q[i] || (ctrl_q && !phase_q)) ? SEG7P_OFF : font[i];
    end
  end

  // Output register stage; dark immediately on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hex_q <= '1;
    end else begin
      hex_q <= hex_d;
    end
  end

  assign hex       = hex_q;
  assign bus.ack   = (state_q == BUS_ACK);
  assign bus.rdata = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_seg7_ctrl
// Brief   : Directed, table-driven bench for seg7_ctrl.
// Rev     : 1.0 - initial release
// ============================================================================
module tb_seg7_ctrl;
  import seg7_ctrl_pkg::*;

  localparam logic [31:0] BASE    = 32'h0000_1000;
  localparam logic [47:0] ALL_OFF = 48'hFFFF_FFFF_FFFF;
  // VAL = 0x561234, DP = 01, BLANK = 00 -> digits 5..0 = 5,6,1,2,3,4(dp lit)
  localparam logic [47:0] SHOW_ALL = 48'h4941_9F25_0D98;
  // same with digit 1 blanked
  localparam logic [47:0] SHOW_B1  = 48'h4941_9F25_FF98;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  seg7p_t [5:0] hex;

  seg7_ctrl_if bus_if ();

  seg7_ctrl #(
    .BASE_ADDR (BASE),
    .BLINK_DIV (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave),
    .hex   (hex)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic        we;
    logic [2:0]  off;
    logic [15:0] wd;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One bus transaction; lat = cycles from first sampling edge to ack, -1 if none
  task automatic xfer(input logic w, input logic [31:0] a, input logic [15:0] d,
                      output logic [15:0] rd, output int lat);
    @(posedge clk);
    @(negedge clk);
    bus_if.req   = 1'b1;
    bus_if.we    = w;
    bus_if.addr  = a;
    bus_if.wdata = d;
    lat = -1;
    rd  = '0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (bus_if.ack) begin
        lat = i;
        rd  = bus_if.rdata;
        break;
      end
    end
    bus_if.req = 1'b0;
  endtask

  function automatic logic [31:0] reg_addr(input logic [2:0] off);
    return BASE | {28'h0, off, 1'b0};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rd;
    int          lat;
    int          nack;
    logic [3:0]  ack_bits;
    logic [15:0] rd_hold;

    tbl[0]  = '{we: 1'b0, off: SEG_BLANK,  wd: 16'h0000, exp: 16'h003F};
    tbl[1]  = '{we: 1'b0, off: SEG_VAL_LO, wd: 16'h0000, exp: 16'h0000};
    tbl[2]  = '{we: 1'b0, off: SEG_CTRL,   wd: 16'h0000, exp: 16'h0000};
    tbl[3]  = '{we: 1'b1, off: SEG_VAL_LO, wd: 16'h1234, exp: 16'h0000};
    tbl[4]  = '{we: 1'b1, off: SEG_VAL_HI, wd: 16'hAB56, exp: 16'h0000};
    tbl[5]  = '{we: 1'b1, off: SEG_BLANK,  wd: 16'h0000, exp: 16'h0000};
    tbl[6]  = '{we: 1'b0, off: SEG_VAL_LO, wd: 16'h0000, exp: 16'h1234};
    tbl[7]  = '{we: 1'b0, off: SEG_VAL_HI, wd: 16'h0000, exp: 16'h0056};
    tbl[8]  = '{we: 1'b0, off: SEG_BLANK,  wd: 16'h0000, exp: 16'h0000};
    tbl[9]  = '{we: 1'b1, off: SEG_DP,     wd: 16'hFFC1, exp: 16'h0000};
    tbl[10] = '{we: 1'b0, off: SEG_DP,     wd: 16'h0000, exp: 16'h0001};
    tbl[11] = '{we: 1'b0, off: 3'd6,       wd: 16'h0000, exp: 16'h0000};
    tbl[12] = '{we: 1'b1, off: 3'd5,       wd: 16'hFFFF, exp: 16'h0000};
    tbl[13] = '{we: 1'b0, off: 3'd5,       wd: 16'h0000, exp: 16'h0000};

    bus_if.req   = 1'b0;
    bus_if.we    = 1'b0;
    bus_if.addr  = '0;
    bus_if.wdata = '0;

    // Asynchronous reset before any clock edge
    #3 rst_n = 1'b0;
    #1;
    chk("reset_hex", hex, ALL_OFF);
    chk("reset_ack", bus_if.ack, 1'b0);
    chk("reset_rdata", bus_if.rdata, 16'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_hex", hex, ALL_OFF);

    // Register access table
    for (int v = 0; v < 14; v++) begin
      xfer(tbl[v].we, reg_addr(tbl[v].off), tbl[v].wd, rd, lat);
      chk($sformatf("vec%0d_latency", v), lat, 0);
      if (!tbl[v].we) chk($sformatf("vec%0d_rdata", v), rd, tbl[v].exp);
    end
    @(posedge clk); #1;
    chk("hex_after_table", hex, SHOW_ALL);

    // Blank all, then unblank: hex changes exactly one edge after the ack
    xfer(1'b1, reg_addr(SEG_BLANK), 16'h003F, rd, lat);
    @(posedge clk); #1;
    chk("hex_blank_all", hex, ALL_OFF);
    xfer(1'b1, reg_addr(SEG_BLANK), 16'h0000, rd, lat);
    chk("hex_in_ack_cycle", hex, ALL_OFF);
    @(posedge clk); #1;
    chk("hex_unblanked", hex, SHOW_ALL);

    // Blank only digit 1
    xfer(1'b1, reg_addr(SEG_BLANK), 16'h0002, rd, lat);
    @(posedge clk); #1;
    chk("hex_blank_d1", hex, SHOW_B1);

    // Blink: on for 4 edges, off for 4, on again
    xfer(1'b1, reg_addr(SEG_CTRL), 16'h0001, rd, lat);
    for (int j = 1; j <= 12; j++) begin
      @(posedge clk); #1;
      chk($sformatf("blink_j%0d", j), hex, (((j - 1) / 4) % 2 == 0) ? SHOW_B1 : ALL_OFF);
    end
    // CTRL write landing on a terminal count where phase is on: no toggle
    repeat (6) @(posedge clk);
    xfer(1'b1, reg_addr(SEG_CTRL), 16'h0001, rd, lat);
    chk("tc_write_latency", lat, 0);
    for (int j = 1; j <= 6; j++) begin
      @(posedge clk); #1;
      chk($sformatf("tc_j%0d", j), hex, (j <= 4) ? SHOW_B1 : ALL_OFF);
    end
    // CTRL write mid-count restarts the prescaler from 0
    @(posedge clk);
    xfer(1'b1, reg_addr(SEG_CTRL), 16'h0001, rd, lat);
    for (int j = 1; j <= 5; j++) begin
      @(posedge clk); #1;
      chk($sformatf("restart_j%0d", j), hex, (j <= 4) ? SHOW_B1 : ALL_OFF);
    end
    xfer(1'b1, reg_addr(SEG_CTRL), 16'h0000, rd, lat);
    repeat (5) @(posedge clk);
    #1;
    chk("blink_off_hex", hex, SHOW_B1);

    // Request held past ack re-fires two cycles later
    @(posedge clk);
    @(negedge clk);
    bus_if.req  = 1'b1;
    bus_if.we   = 1'b0;
    bus_if.addr = reg_addr(SEG_BLANK);
    ack_bits    = '0;
    rd_hold     = 16'hDEAD;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      ack_bits[i] = bus_if.ack;
      if (i == 0) rd = bus_if.rdata;
      if (i == 1) rd_hold = bus_if.rdata;
    end
    bus_if.req = 1'b0;
    chk("held_req_ack_pattern", ack_bits, 4'b0101);
    chk("held_req_rdata", rd, 16'h0002);
    chk("rdata_zero_without_ack", rd_hold, 16'h0000);

    // Addresses outside the window never ack
    nack = 0;
    @(posedge clk);
    @(negedge clk);
    bus_if.req  = 1'b1;
    bus_if.addr = 32'h0000_2006;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (bus_if.ack) nack++;
    end
    bus_if.addr = 32'h0000_0FFE;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (bus_if.ack) nack++;
    end
    bus_if.req = 1'b0;
    chk("miss_no_ack", nack, 0);

    // Reset asserted during the ack of a VAL_LO write
    @(posedge clk);
    @(negedge clk);
    bus_if.req   = 1'b1;
    bus_if.we    = 1'b1;
    bus_if.addr  = reg_addr(SEG_VAL_LO);
    bus_if.wdata = 16'hBEEF;
    @(posedge clk); #1;
    chk("rst_seq_ack_seen", bus_if.ack, 1'b1);
    rst_n      = 1'b0;
    bus_if.req = 1'b0;
    #1;
    chk("rst_seq_ack_drop", bus_if.ack, 1'b0);
    chk("rst_seq_rdata_drop", bus_if.rdata, 16'h0);
    chk("rst_seq_hex", hex, ALL_OFF);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    xfer(1'b0, reg_addr(SEG_VAL_LO), 16'h0, rd, lat);
    chk("rst_seq_val_lo", rd, 16'h0000);
    xfer(1'b0, reg_addr(SEG_BLANK), 16'h0, rd, lat);
    chk("rst_seq_blank", rd, 16'h003F);
    xfer(1'b0, reg_addr(SEG_DP), 16'h0, rd, lat);
    chk("rst_seq_dp", rd, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
